mem_stage: RTL and testbench

- MIPS pipeline MEM stage, directly downstream of the EX stage; consumes the EX/MEM pipeline register.
- Performs loads and stores over a request/acknowledge data-memory port with variable latency, plus byte-lane steering and load sign/zero extension.
- Stalls the pipeline while a memory access is outstanding, aborts on timeout or misalignment, and owns the MEM/WB pipeline register.
- Provides forwarding values to the EX stage.

---
 rtl/mem_stage.sv | 178 +++++++++++++++++
 tb/tb_mem_stage.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MIPS MEM stage: request/ack data-memory access with lane steering, load extension,
// stall/timeout handling, and ownership of the MEM/WB pipeline register.
module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] EX_MEM_alu_result,
  input  logic [31:0] EX_MEM_B_value,
  input  logic [4:0]  EX_MEM_dst_reg,
  input  logic [5:0]  EX_MEM_opcode,
  input  logic        EX_MEM_mem_read,
  input  logic        EX_MEM_mem_write,
  input  logic        EX_MEM_wb_reg_write,
  input  logic        EX_MEM_wb_mem_to_reg,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [31:0] mem_fwd_val,
  output logic [31:0] wb_fwd_val,
  output logic [31:0] MEM_WB_read_data,
  output logic [31:0] MEM_WB_alu_result,
  output logic [4:0]  MEM_WB_dst_reg,
  output logic        MEM_WB_reg_write,
  output logic        MEM_WB_mem_to_reg,
  output logic        mem_err
);

  localparam int unsigned CNT_W = 16;
  localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25, OP_SB = 6'h28, OP_SH = 6'h29;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               is_byte, is_half, is_signed;
  logic [1:0]         lane;
  logic               access, misaligned, mem_op, is_load;
  logic               done, abort;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic [31:0]        load_data;

  // Access size and sign handling from the opcode
  always_comb begin
    is_byte   = 1'b0;
    is_half   = 1'b0;
    is_signed = 1'b0;
    case (EX_MEM_opcode)
      OP_LB:         begin is_byte = 1'b1; is_signed = 1'b1; end
      OP_LBU, OP_SB: is_byte = 1'b1;
      OP_LH:         begin is_half = 1'b1; is_signed = 1'b1; end
      OP_LHU, OP_SH: is_half = 1'b1;
      default:       ;
    endcase
  end

  assign lane       = EX_MEM_alu_result[1:0];
  assign access     = EX_MEM_mem_read | EX_MEM_mem_write;
  assign misaligned = access & ((is_half & lane[0]) | (~is_byte & ~is_half & (lane != 2'b00)));
  assign mem_op     = access & ~misaligned;
  assign is_load    = EX_MEM_mem_read & ~EX_MEM_mem_write;

  // Store lane steering; loads always enable all lanes
  always_comb begin
    dmem_addr  = {EX_MEM_alu_result[31:2], 2'b00};
    dmem_we    = EX_MEM_mem_write;
    dmem_be    = 4'b1111;
    dmem_wdata = EX_MEM_B_value;
    if (is_byte) begin
      dmem_wdata = {4{EX_MEM_B_value[7:0]}};
      if (EX_MEM_mem_write) dmem_be = 4'b0001 << lane;
    end else if (is_half) begin
      dmem_wdata = {2{EX_MEM_B_value[15:0]}};
      if (EX_MEM_mem_write) dmem_be = lane[1] ? 4'b1100 : 4'b0011;
    end
  end

  // Load lane selection and extension
  always_comb begin
    case (lane)
      2'd0:    byte_sel = dmem_rdata[7:0];
      2'd1:    byte_sel = dmem_rdata[15:8];
      2'd2:    byte_sel = dmem_rdata[23:16];
      default: byte_sel = dmem_rdata[31:24];
    endcase
    half_sel  = lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_data = dmem_rdata;
    if (is_byte)
      load_data = is_signed ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
    else if (is_half)
      load_data = is_signed ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake; ack beats timeout in WAIT
  always_comb begin
    state_nxt = state;
    dmem_req  = 1'b0;
    mem_stall = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_op) begin
          dmem_req = 1'b1;
          if (dmem_ack) begin
            done = 1'b1;
          end else begin
            mem_stall = 1'b1;
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          abort     = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (rst) begin
      dmem_req  = 1'b0;
      mem_stall = 1'b0;
    end
  end

  // Wait counter: held at zero in IDLE, counts cycles spent in WAIT
  always_ff @(posedge clk) begin
    if (rst || state == ST_IDLE) cnt <= '0;
    else                         cnt <= cnt + CNT_W'(1);
  end

  // MEM/WB register: bubble while stalled, capture otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      MEM_WB_read_data  <= '0;
      MEM_WB_alu_result <= '0;
      MEM_WB_dst_reg    <= '0;
      MEM_WB_reg_write  <= 1'b0;
      MEM_WB_mem_to_reg <= 1'b0;
      mem_err           <= 1'b0;
    end else begin
      mem_err <= misaligned | abort;
      if (mem_stall) begin
        MEM_WB_reg_write  <= 1'b0;
        MEM_WB_mem_to_reg <= 1'b0;
      end else begin
        MEM_WB_read_data  <= (done & is_load) ? load_data : 32'h0;
        MEM_WB_alu_result <= EX_MEM_alu_result;
        MEM_WB_dst_reg    <= EX_MEM_dst_reg;
        MEM_WB_reg_write  <= EX_MEM_wb_reg_write & ~misaligned & ~abort;
        MEM_WB_mem_to_reg <= EX_MEM_wb_mem_to_reg;
      end
    end
  end

  assign mem_fwd_val = EX_MEM_alu_result;
  assign wb_fwd_val  = MEM_WB_mem_to_reg ? MEM_WB_read_data : MEM_WB_alu_result;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized transactions
// checked against a transaction-level reference model.
module tb_mem_stage;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] EX_MEM_alu_result, EX_MEM_B_value;
  logic [4:0]  EX_MEM_dst_reg;
  logic [5:0]  EX_MEM_opcode;
  logic        EX_MEM_mem_read, EX_MEM_mem_write, EX_MEM_wb_reg_write, EX_MEM_wb_mem_to_reg;
  logic        dmem_req, dmem_we, dmem_ack, mem_stall, MEM_WB_reg_write, MEM_WB_mem_to_reg, mem_err;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, mem_fwd_val, wb_fwd_val;
  logic [31:0] MEM_WB_read_data, MEM_WB_alu_result;
  logic [3:0]  dmem_be;
  logic [4:0]  MEM_WB_dst_reg;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .EX_MEM_alu_result(EX_MEM_alu_result), .EX_MEM_B_value(EX_MEM_B_value),
    .EX_MEM_dst_reg(EX_MEM_dst_reg), .EX_MEM_opcode(EX_MEM_opcode),
    .EX_MEM_mem_read(EX_MEM_mem_read), .EX_MEM_mem_write(EX_MEM_mem_write),
    .EX_MEM_wb_reg_write(EX_MEM_wb_reg_write), .EX_MEM_wb_mem_to_reg(EX_MEM_wb_mem_to_reg),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val),
    .MEM_WB_read_data(MEM_WB_read_data), .MEM_WB_alu_result(MEM_WB_alu_result),
    .MEM_WB_dst_reg(MEM_WB_dst_reg), .MEM_WB_reg_write(MEM_WB_reg_write),
    .MEM_WB_mem_to_reg(MEM_WB_mem_to_reg), .mem_err(mem_err)
  );

  function automatic int size_of(input logic [5:0] op);
    if (op == 6'h20 || op == 6'h24 || op == 6'h28) return 1;
    if (op == 6'h21 || op == 6'h25 || op == 6'h29) return 2;
    return 4;
  endfunction

  // Little-endian extraction by shifting, then sign fix-up by subtraction
  function automatic logic [31:0] load_val(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] rdata);
    logic [31:0] w;
    w = rdata >> (8 * a[1:0]);
    if (size_of(op) == 1) begin
      w = w & 32'hFF;
      if (op == 6'h20 && w >= 32'h80) w = w - 32'h100;
    end else if (size_of(op) == 2) begin
      w = w & 32'hFFFF;
      if (op == 6'h21 && w >= 32'h8000) w = w - 32'h10000;
    end else begin
      w = rdata;
    end
    return w;
  endfunction

  // Runs one instruction through MEM; entered and left at posedge+1
  task automatic do_txn(input logic [5:0] op, input logic rd, input logic wr, input logic rw,
                        input logic m2r, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] dst, input int lat, input logic [31:0] rdata);
    int sz, nst;
    logic mis, memop, load, abort, rd_def;
    logic [3:0] ebe;
    logic [31:0] ewd, erd, efwd;
    sz    = size_of(op);
    mis   = (rd || wr) && ((sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00));
    memop = (rd || wr) && !mis;
    load  = rd && !wr;
    nst   = !memop ? 0 : (lat < int'(TO) ? lat : int'(TO));
    abort = memop && lat > int'(TO);
    ebe   = 4'hF;
    ewd   = b;
    if (sz == 1) begin
      ewd = {24'h0, b[7:0]} * 32'h01010101;
      if (wr) ebe = 4'(1 << a[1:0]);
    end else if (sz == 2) begin
      ewd = {16'h0, b[15:0]} * 32'h00010001;
      if (wr) ebe = a[1] ? 4'hC : 4'h3;
    end
    EX_MEM_opcode = op; EX_MEM_mem_read = rd; EX_MEM_mem_write = wr;
    EX_MEM_wb_reg_write = rw; EX_MEM_wb_mem_to_reg = m2r;
    EX_MEM_alu_result = a; EX_MEM_B_value = b; EX_MEM_dst_reg = dst;
    for (int k = 0; k <= nst; k++) begin
      @(negedge clk);
      dmem_ack   = memop && (k == lat);
      dmem_rdata = dmem_ack ? rdata : $urandom();
      #1;
      checks++;
      if (dmem_req !== memop) begin failures++; $display("FAIL req cyc%0d got=%b exp=%b", k, dmem_req, memop); end
      checks++;
      if (mem_stall !== (k < nst)) begin failures++; $display("FAIL stall cyc%0d got=%b exp=%b", k, mem_stall, k < nst); end
      checks++;
      if (mem_fwd_val !== a) begin failures++; $display("FAIL mem_fwd got=%h exp=%h", mem_fwd_val, a); end
      if (memop) begin
        checks++;
        if ({dmem_addr, dmem_we, dmem_be} !== {a & 32'hFFFF_FFFC, wr, ebe}) begin
          failures++;
          $display("FAIL dmem_ctl cyc%0d got=%h/%b/%b exp=%h/%b/%b", k, dmem_addr, dmem_we, dmem_be,
                   a & 32'hFFFF_FFFC, wr, ebe);
        end
        if (wr) begin
          checks++;
          if (dmem_wdata !== ewd) begin failures++; $display("FAIL wdata got=%h exp=%h", dmem_wdata, ewd); end
        end
      end
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      if (k < nst) begin
        checks++;
        if ({MEM_WB_reg_write, MEM_WB_mem_to_reg, mem_err} !== 3'b000) begin
          failures++;
          $display("FAIL bubble cyc%0d got=%b%b%b exp=000", k, MEM_WB_reg_write, MEM_WB_mem_to_reg, mem_err);
        end
      end
    end
    checks++;
    if ({MEM_WB_alu_result, MEM_WB_dst_reg} !== {a, dst}) begin
      failures++; $display("FAIL wb_alu_dst got=%h/%0d exp=%h/%0d", MEM_WB_alu_result, MEM_WB_dst_reg, a, dst);
    end
    checks++;
    if (MEM_WB_reg_write !== (rw && !mis && !abort)) begin
      failures++; $display("FAIL wb_reg_write got=%b exp=%b", MEM_WB_reg_write, rw && !mis && !abort);
    end
    checks++;
    if (MEM_WB_mem_to_reg !== m2r) begin failures++; $display("FAIL wb_mem_to_reg got=%b exp=%b", MEM_WB_mem_to_reg, m2r); end
    checks++;
    if (mem_err !== (mis || abort)) begin failures++; $display("FAIL mem_err got=%b exp=%b", mem_err, mis || abort); end
    rd_def = abort || (load && memop);
    erd    = abort ? 32'h0 : load_val(op, a, rdata);
    if (rd_def) begin
      checks++;
      if (MEM_WB_read_data !== erd) begin failures++; $display("FAIL wb_read_data got=%h exp=%h", MEM_WB_read_data, erd); end
    end
    if (rd_def || !m2r) begin
      efwd = m2r ? erd : a;
      checks++;
      if (wb_fwd_val !== efwd) begin failures++; $display("FAIL wb_fwd got=%h exp=%h", wb_fwd_val, efwd); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    EX_MEM_opcode = 6'h23; EX_MEM_mem_read = 1'b1; EX_MEM_mem_write = 1'b0;
    EX_MEM_alu_result = 32'h100; EX_MEM_B_value = 32'h0; EX_MEM_dst_reg = 5'd1;
    EX_MEM_wb_reg_write = 1'b1; EX_MEM_wb_mem_to_reg = 1'b1;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({MEM_WB_read_data, MEM_WB_alu_result, MEM_WB_dst_reg, MEM_WB_reg_write, MEM_WB_mem_to_reg, mem_err} !== '0) begin
      failures++; $display("FAIL reset_regs got=%h/%h/%0d/%b/%b/%b exp=0", MEM_WB_read_data, MEM_WB_alu_result,
                           MEM_WB_dst_reg, MEM_WB_reg_write, MEM_WB_mem_to_reg, mem_err);
    end
    @(negedge clk); #1;
    checks++;
    if ({dmem_req, mem_stall} !== 2'b00) begin failures++; $display("FAIL reset_req_stall got=%b%b exp=00", dmem_req, mem_stall); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_zero_wait_lw();
    do_txn(6'h23, 1, 0, 1, 1, 32'h100, 32'h0, 5'd3, 0, 32'hDEADBEEF);
    checks++;
    if (MEM_WB_read_data !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_data got=%h exp=deadbeef", MEM_WB_read_data); end
  endtask

  task automatic test_byte_loads();
    do_txn(6'h20, 1, 0, 1, 1, 32'h103, 32'h0, 5'd4, 0, 32'h80112233);
    checks++;
    if (MEM_WB_read_data !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_data got=%h exp=ffffff80", MEM_WB_read_data); end
    do_txn(6'h24, 1, 0, 1, 1, 32'h103, 32'h0, 5'd5, 1, 32'h80112233);
    checks++;
    if (MEM_WB_read_data !== 32'h00000080) begin failures++; $display("FAIL lbu_data got=%h exp=00000080", MEM_WB_read_data); end
    do_txn(6'h21, 1, 0, 1, 1, 32'h102, 32'h0, 5'd6, 2, 32'h8001_7FFF);
  endtask

  task automatic test_store_half();
    EX_MEM_opcode = 6'h29; EX_MEM_mem_read = 1'b0; EX_MEM_mem_write = 1'b1;
    EX_MEM_alu_result = 32'h202; EX_MEM_B_value = 32'h0000ABCD;
    #1;
    checks++;
    if ({dmem_addr, dmem_be, dmem_wdata, dmem_we} !== {32'h200, 4'b1100, 32'hABCDABCD, 1'b1}) begin
      failures++; $display("FAIL sh_steer got=%h/%b/%h/%b exp=00000200/1100/abcdabcd/1", dmem_addr, dmem_be, dmem_wdata, dmem_we);
    end
    do_txn(6'h29, 0, 1, 0, 0, 32'h202, 32'h0000ABCD, 5'd0, 0, 32'h0);
  endtask

  task automatic test_stall_sw();
    do_txn(6'h2B, 0, 1, 0, 0, 32'h300, 32'h12345678, 5'd0, 3, 32'h0);
    do_txn(6'h00, 0, 0, 1, 0, 32'hCAFE0001, 32'h0, 5'd7, 0, 32'h0);
  endtask

  task automatic test_timeout();
    do_txn(6'h23, 1, 0, 1, 1, 32'h400, 32'h0, 5'd8, 99, 32'h0);
    do_txn(6'h00, 0, 0, 1, 0, 32'h44, 32'h0, 5'd9, 0, 32'h0);
    do_txn(6'h23, 1, 0, 1, 1, 32'h404, 32'h0, 5'd10, int'(TO), 32'h5555AAAA);
  endtask

  task automatic test_misaligned();
    do_txn(6'h23, 1, 0, 1, 1, 32'h101, 32'h0, 5'd11, 0, 32'h0);
    do_txn(6'h29, 0, 1, 0, 0, 32'h201, 32'hFFFF, 5'd0, 0, 32'h0);
    do_txn(6'h28, 0, 1, 0, 0, 32'h203, 32'h5A, 5'd0, 1, 32'h0);
  endtask

  task automatic test_reset_in_wait();
    EX_MEM_opcode = 6'h23; EX_MEM_mem_read = 1'b1; EX_MEM_mem_write = 1'b0;
    EX_MEM_alu_result = 32'h500; EX_MEM_wb_reg_write = 1'b1; EX_MEM_wb_mem_to_reg = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({dmem_req, mem_stall} !== 2'b00) begin failures++; $display("FAIL rst_wait_req_stall got=%b%b exp=00", dmem_req, mem_stall); end
    @(posedge clk); #1;
    checks++;
    if ({MEM_WB_read_data, MEM_WB_alu_result, MEM_WB_dst_reg, MEM_WB_reg_write, MEM_WB_mem_to_reg, mem_err} !== '0) begin
      failures++; $display("FAIL rst_wait_regs got=%h/%h/%b exp=0", MEM_WB_read_data, MEM_WB_alu_result, MEM_WB_reg_write);
    end
    rst = 1'b0;
    EX_MEM_opcode = 6'h00; EX_MEM_mem_read = 1'b0; EX_MEM_wb_reg_write = 1'b0; EX_MEM_wb_mem_to_reg = 1'b0;
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 32'h13579BDF;
    #1;
    checks++;
    if ({dmem_req, mem_stall} !== 2'b00) begin failures++; $display("FAIL late_ack got=%b%b exp=00", dmem_req, mem_stall); end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    checks++;
    if ({MEM_WB_reg_write, mem_err} !== 2'b00) begin failures++; $display("FAIL late_ack_wb got=%b%b exp=00", MEM_WB_reg_write, mem_err); end
    do_txn(6'h23, 1, 0, 1, 1, 32'h600, 32'h0, 5'd12, 0, 32'h0BADF00D);
  endtask

  task automatic test_random();
    logic [5:0] ops [9];
    logic [5:0] op;
    logic rd, wr;
    logic [31:0] a;
    ops = '{6'h23, 6'h20, 6'h24, 6'h21, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h00};
    for (int i = 0; i < 300; i++) begin
      op = ops[$urandom_range(0, 8)];
      rd = (op >= 6'h20 && op <= 6'h25) || op == 6'h23;
      wr = (op == 6'h28 || op == 6'h29 || op == 6'h2B);
      if (op == 6'h2B && $urandom_range(0, 3) == 0) rd = 1'b1;
      a = $urandom();
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      do_txn(op, rd, wr, 1'($urandom_range(0, 1)), rd, a, $urandom(), 5'($urandom_range(0, 31)),
             $urandom_range(0, 5), $urandom());
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait_lw();
    test_byte_loads();
    test_store_half();
    test_stall_sw();
    test_timeout();
    test_misaligned();
    test_reset_in_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
